uart_tx_frame_engine: RTL
=========================

Name: uart_tx_frame_engine

Overview:
Parametrised UART transmit engine used as the RTL counterpart and reference DUT for the UART agent's transmit path. It buffers characters in a FIFO and serialises each one onto a single line as start, data, optional parity and stop bits. Character length, bit order, parity, stop-bit count, oversampling and baud divisor are all selectable at run time, so one build covers every uart_type, stop_bit and parity combination the verification environment drives.

Parameters:
MAX_CHAR_LENGTH, 8, widest character supported; run-time uart_type must be in 5..MAX_CHAR_LENGTH.
FIFO_DEPTH, 16, transmit FIFO entries; must be a power of 2 and at least 2.
DIV_WIDTH, 16, width of the baud divisor.

Ports:
pclk  in  1  system clock.
areset  in  1  asynchronous reset, active-high.
cfg_baud_div  in  DIV_WIDTH  pclk cycles per oversample tick.
cfg_oversampling  in  4  ticks per bit; legal values are 2, 4, 6, 8.
cfg_uart_type  in  4  data bits per character; legal values are 5..8.
cfg_msb_first  in  1  1 = MSB shifted out first.
cfg_parity_en  in  1  1 = insert parity bit.
cfg_parity_scheme  in  1  0 = even parity, 1 = odd parity.
cfg_stop_bit  in  2  1 = one stop bit, 0 = one-and-a-half, 2 = two.
wr_valid  in  1  push request.
wr_data  in  MAX_CHAR_LENGTH  character to send; only the low uart_type bits are used.
wr_ready  out  1  FIFO not full.
tx  out  1  serial line, idles high.
busy  out  1  a frame is in progress.
frame_done  out  1  one-cycle pulse on the last cycle of the stop period.
cfg_error  out  1  the current cfg_* inputs are illegal.
fifo_level  out  $clog2(FIFO_DEPTH+1)  number of occupied entries.

Behaviour:
- Reset values (asynchronous): tx=1, busy=0, frame_done=0, fifo_level=0, wr_ready=1, FSM in IDLE, all counters 0.
- Reset mid-frame: tx returns high immediately, the FIFO is emptied and the partial frame is discarded.
- Push: a character is accepted when wr_valid && wr_ready. wr_ready = !full.
- Push and pop in the same cycle: fifo_level is unchanged. When the FIFO is full, wr_ready=0 blocks the push even if a pop happens in that cycle.
- cfg_error is combinational. It is 1 if baud_div==0, or oversampling is not in {2,4,6,8}, or uart_type is not in 5..MAX_CHAR_LENGTH, or stop_bit==3.
- Frame start: in IDLE, if the FIFO is not empty and cfg_error==0, the engine pops one character and latches all cfg_* values. cfg changes during a frame have no effect until the next frame.
- Timing: tx goes low on the cycle after the pop. busy rises on the same cycle as tx goes low.
- Bit-period generator: a divisor counter runs 0..baud_div-1 and produces one tick per wrap. A tick counter runs 0..oversampling-1. One bit period is baud_div*oversampling pclk cycles.
- FSM states and transitions:
  - IDLE -> START on pop.
  - START (tx=0) lasts one bit period, then -> DATA.
  - DATA sends uart_type bits, one bit period each. Order is bit0 first, or bit[uart_type-1] first when msb_first=1. Then -> PARITY if parity_en, else -> STOP.
  - PARITY sends one bit period of the XOR of the sent data bits for even parity, or its inverse for odd parity. Then -> STOP.
  - STOP (tx=1) lasts 1, 1.5 or 2 bit periods. 1.5 is implemented as oversampling*3/2 ticks, which is why only even oversampling values are legal.
  - End of STOP -> IDLE.
- frame_done pulses on the final cycle of STOP.
- Back-to-back frames: if the FIFO is not empty at frame_done, the next pop happens in the IDLE cycle that follows. tx stays high for exactly one pclk and busy drops for that one cycle.
- FIFO contents are never altered by cfg_error. Characters wait until the configuration becomes legal.

Decomposition:
- Shared globals package gets: MAX_CHAR_LENGTH, the stop_bit encodings (one=1, one-and-a-half=0, two=2), uart_type_e, parity_e, oversampling_e, and a new tx_fsm_state_e enum {IDLE, START, DATA, PARITY, STOP}. Legal-value checks live as a package function.
- Sub-module: uart_sync_fifo (parameter DEPTH, WIDTH; push, pop, full, empty, level).

Test Plan:
1. baud_div=1, ovs=2, 8-bit, LSB first, no parity, 1 stop, push 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 2 cycles; frame_done after 20 cycles; busy low afterwards.
2. 5-bit, MSB first, even parity, 2 stop, ovs=4, baud_div=2, push 0x13 -> data bits 1,0,0,1,1, parity 1; two stop bits; each bit 8 cycles; frame 72 cycles.
3. 7-bit, odd parity, 1.5 stop, ovs=6, baud_div=1, push 0x7F -> parity 0; stop period exactly 9 cycles.
4. FIFO_DEPTH=16, 17 pushes while cfg_error=1 (baud_div=0) -> wr_ready drops after the 16th push; fifo_level=16; tx stays high. Set baud_div=1 -> characters are sent in order, one idle cycle between frames.
5. Change cfg_uart_type from 8 to 6 mid-frame -> the current frame still sends 8 data bits; the next frame sends 6.
6. Assert areset in the middle of the DATA state with 3 characters queued -> tx=1, fifo_level=0, busy=0 immediately; no frame_done pulse.

Source files
------------

// File: rtl/uart_tx_frame_engine_pkg.sv
// Shared types and constants for the UART transmit frame engine.
// Also holds the legality check applied to the run-time configuration.
package uart_tx_frame_engine_pkg;

  localparam int MAX_CHAR_LENGTH = 8;

  localparam logic [1:0] STOP_ONE      = 2'd1;
  localparam logic [1:0] STOP_ONE_HALF = 2'd0;
  localparam logic [1:0] STOP_TWO      = 2'd2;

  typedef enum logic [3:0] {
    UART_5 = 4'd5,
    UART_6 = 4'd6,
    UART_7 = 4'd7,
    UART_8 = 4'd8
  } uart_type_e;

  typedef enum logic {
    PARITY_EVEN = 1'b0,
    PARITY_ODD  = 1'b1
  } parity_e;

  typedef enum logic [3:0] {
    OVS_2 = 4'd2,
    OVS_4 = 4'd4,
    OVS_6 = 4'd6,
    OVS_8 = 4'd8
  } oversampling_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_fsm_state_e;

  // Odd oversampling cannot produce an integral 1.5-bit stop period.
  function automatic logic cfg_illegal(
    input logic       div_zero,
    input logic [3:0] ovs,
    input logic [3:0] utype,
    input logic [1:0] stop,
    input int         max_len
  );
    logic ovs_ok;
    logic type_ok;
    ovs_ok  = (ovs == OVS_2) || (ovs == OVS_4) || (ovs == OVS_6) || (ovs == OVS_8);
    type_ok = (utype >= 4'd5) && (int'(utype) <= max_len);
    return div_zero || !ovs_ok || !type_ok || (stop == 2'd3);
  endfunction

endpackage

// File: rtl/uart_tx_frame_engine_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on rd_data while
// the FIFO is non-empty. A push into a full FIFO is dropped.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wr_data,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_reg == LVL_W'(DEPTH));
  assign empty   = (level_reg == '0);
  assign level   = level_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_frame_engine.sv
// UART transmit engine: buffers characters and serialises start, data,
// optional parity and stop bits with a run-time selectable frame format.
module uart_tx_frame_engine #(
  parameter int MAX_CHAR_LENGTH = uart_tx_frame_engine_pkg::MAX_CHAR_LENGTH,
  parameter int FIFO_DEPTH      = 16,
  parameter int DIV_WIDTH       = 16
) (
  input  logic                               pclk,
  input  logic                               areset,
  input  logic [DIV_WIDTH-1:0]               cfg_baud_div,
  input  logic [3:0]                         cfg_oversampling,
  input  logic [3:0]                         cfg_uart_type,
  input  logic                               cfg_msb_first,
  input  logic                               cfg_parity_en,
  input  logic                               cfg_parity_scheme,
  input  logic [1:0]                         cfg_stop_bit,
  input  logic                               wr_valid,
  input  logic [MAX_CHAR_LENGTH-1:0]         wr_data,
  output logic                               wr_ready,
  output logic                               tx,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               cfg_error,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  import uart_tx_frame_engine_pkg::*;

  tx_fsm_state_e               state_reg;
  logic                        tx_reg;
  logic                        busy_reg;
  logic [DIV_WIDTH-1:0]        div_cnt_reg;
  logic [4:0]                  tick_cnt_reg;
  logic [3:0]                  bit_idx_reg;

  logic [DIV_WIDTH-1:0]        lat_div_reg;
  logic [3:0]                  lat_ovs_reg;
  logic [3:0]                  lat_type_reg;
  logic                        lat_msb_reg;
  logic                        lat_par_en_reg;
  parity_e                     lat_par_reg;
  logic [1:0]                  lat_stop_reg;
  logic [MAX_CHAR_LENGTH-1:0]  lat_data_reg;

  logic [MAX_CHAR_LENGTH-1:0]  fifo_rd_data;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        start_frame;
  logic                        tick;
  logic                        period_end;
  logic                        last_bit;
  logic                        parity_bit;
  logic                        next_bit;
  logic [4:0]                  stop_ticks;
  logic [4:0]                  period_ticks;
  logic [3:0]                  next_idx;
  logic [3:0]                  bit_pos;
  logic [15:0]                 data_ext;
  logic [MAX_CHAR_LENGTH-1:0]  type_mask;

  assign cfg_error   = cfg_illegal(cfg_baud_div == '0, cfg_oversampling, cfg_uart_type,
                                   cfg_stop_bit, MAX_CHAR_LENGTH);
  assign wr_ready    = !fifo_full;
  assign start_frame = (state_reg == IDLE) && !fifo_empty && !cfg_error;
  assign tx          = tx_reg;
  assign busy        = busy_reg;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (MAX_CHAR_LENGTH)
  ) u_fifo (
    .clk     (pclk),
    .rst     (areset),
    .push    (wr_valid && wr_ready),
    .pop     (start_frame),
    .wr_data (wr_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Only the low uart_type bits take part in parity.
  for (genvar gi = 0; gi < MAX_CHAR_LENGTH; gi++) begin : g_mask
    assign type_mask[gi] = (gi < int'(lat_type_reg));
  end

  always_comb begin
    tick     = (div_cnt_reg == lat_div_reg - DIV_WIDTH'(1));
    case (lat_stop_reg)
      STOP_ONE_HALF: stop_ticks = {1'b0, lat_ovs_reg} + {2'b00, lat_ovs_reg[3:1]};
      STOP_TWO:      stop_ticks = {lat_ovs_reg, 1'b0};
      default:       stop_ticks = {1'b0, lat_ovs_reg};
    endcase
    period_ticks = (state_reg == STOP) ? stop_ticks : {1'b0, lat_ovs_reg};
    period_end   = tick && (tick_cnt_reg == period_ticks - 5'd1);
    last_bit     = (bit_idx_reg == lat_type_reg - 4'd1);
    next_idx     = (state_reg == START) ? 4'd0 : bit_idx_reg + 4'd1;
    bit_pos      = lat_msb_reg ? (lat_type_reg - 4'd1 - next_idx) : next_idx;
    data_ext     = '0;
    data_ext[MAX_CHAR_LENGTH-1:0] = lat_data_reg;
    next_bit     = data_ext[bit_pos];
    parity_bit   = (^(lat_data_reg & type_mask)) ^ (lat_par_reg == PARITY_ODD);
  end

  assign frame_done = (state_reg == STOP) && period_end;

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      state_reg      <= IDLE;
      tx_reg         <= 1'b1;
      busy_reg       <= 1'b0;
      div_cnt_reg    <= '0;
      tick_cnt_reg   <= '0;
      bit_idx_reg    <= '0;
      lat_div_reg    <= '0;
      lat_ovs_reg    <= '0;
      lat_type_reg   <= '0;
      lat_msb_reg    <= 1'b0;
      lat_par_en_reg <= 1'b0;
      lat_par_reg    <= PARITY_EVEN;
      lat_stop_reg   <= '0;
      lat_data_reg   <= '0;
    end else if (state_reg == IDLE) begin
      div_cnt_reg  <= '0;
      tick_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      if (start_frame) begin
        state_reg      <= START;
        tx_reg         <= 1'b0;
        busy_reg       <= 1'b1;
        lat_div_reg    <= cfg_baud_div;
        lat_ovs_reg    <= cfg_oversampling;
        lat_type_reg   <= cfg_uart_type;
        lat_msb_reg    <= cfg_msb_first;
        lat_par_en_reg <= cfg_parity_en;
        lat_par_reg    <= parity_e'(cfg_parity_scheme);
        lat_stop_reg   <= cfg_stop_bit;
        lat_data_reg   <= fifo_rd_data;
      end
    end else begin
      if (tick) begin
        div_cnt_reg  <= '0;
        tick_cnt_reg <= period_end ? 5'd0 : tick_cnt_reg + 5'd1;
      end else begin
        div_cnt_reg  <= div_cnt_reg + DIV_WIDTH'(1);
      end
      if (period_end) begin
        case (state_reg)
          START: begin
            state_reg <= DATA;
            tx_reg    <= next_bit;
          end
          DATA: begin
            if (last_bit) begin
              bit_idx_reg <= '0;
              state_reg   <= lat_par_en_reg ? PARITY : STOP;
              tx_reg      <= lat_par_en_reg ? parity_bit : 1'b1;
            end else begin
              bit_idx_reg <= next_idx;
              tx_reg      <= next_bit;
            end
          end
          PARITY: begin
            state_reg <= STOP;
            tx_reg    <= 1'b1;
          end
          STOP: begin
            state_reg <= IDLE;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
          end
          default: begin
            state_reg <= IDLE;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
